bin2gray_counter: RTL and testbench
===================================

// Module: bin2gray_counter
// PURPOSE
//  Registered binary up/down counter with a registered 4-bit Gray-code
//  output. The Gray output changes exactly one bit per count step.
//  Sits on the encode side of the Gray path: it generates Gray pointers and
//  codes that downstream logic (for example clock-domain-crossing pointer
//  synchronisers) decodes back to binary.
//  Supports parallel load, count enable, count direction and a wrap pulse.
// PARAMETERS
//  WIDTH      4   counter and Gray code width in bits (>= 2)
//  RESET_VAL  0   binary value loaded on reset (WIDTH bits)
// PORTS
//  clk       in   1      rising-edge clock; the only clock
//  rst       in   1      asynchronous active-high reset
//  load      in   1      synchronous load of load_bin; highest priority
//  load_bin  in   WIDTH  binary value to load
//  inc_en    in   1      count enable; one step per clk while high
//  dir       in   1      1 = count up, 0 = count down
//  bin_q     out  WIDTH  registered binary count
//  gray_q    out  WIDTH  registered Gray code of bin_q: b ^ (b >> 1)
//  wrap      out  1      one-cycle pulse on a terminal-count crossing
// BEHAVIOUR
//  - Reset (async assert; release is sampled on clk):
//      bin_q  = RESET_VAL
//      gray_q = bin2gray(RESET_VAL)
//      wrap   = 0
//  - Next-state priority per clk edge: load > inc_en > hold.
//  - load = 1:
//      bin_q  <= load_bin
//      gray_q <= bin2gray(load_bin); multiple bits may change
//      wrap   <= 0, even if inc_en is also high
//  - inc_en = 1, load = 0:
//      bin_q <= bin_q + 1 (dir = 1) or bin_q - 1 (dir = 0), modulo 2^WIDTH
//      gray_q <= bin2gray of that same next value
//  - Latency: bin_q and gray_q update on the same edge; zero skew between them.
//    gray_q is computed from next_bin, not derived from bin_q one cycle later.
//  - gray_q is taken directly from a flop; no combinational logic on the output.
//  - wrap <= 1 only when inc_en = 1, load = 0 and either:
//      up:   bin_q == 2^WIDTH - 1  (15 -> 0, gray 1000 -> 0000)
//      down: bin_q == 0            (0 -> 15, gray 0000 -> 1000)
//    Otherwise wrap <= 0. wrap is high for a single cycle per crossing.
//  - Hold (inc_en = 0, load = 0): all outputs keep their values; wrap <= 0.
//  - A direction change mid-count takes effect on the next step, with no bubble.
//  - Single-step invariant: on a count step, popcount(gray_q_old ^ gray_q_new) == 1.
//  - Reset mid-count: outputs go to reset values immediately; there is no partial update.
// STRUCTURE
//  - Shared package/include gray_pkg:
//      function bin2gray(b) = b ^ (b >> 1)
//      localparam GRAY_W_DEFAULT = 4
//  - One sub-module, bin2gray_comb: purely combinational, WIDTH-parameterised.
//      Instantiated on next_bin; its output feeds the gray_q flops.
//  - Top level contains: next-state mux (load / up / down / hold),
//    terminal-count detect, output flops.
// TESTING
//  1. Reset with RESET_VAL = 0, then release
//     -> bin_q = 0000, gray_q = 0000, wrap = 0.
//  2. Hold dir = 1, inc_en = 1 for 16 clks.
//     -> gray_q sequence: 0001 0011 0010 0110 0111 0101 0100 1100 1101 1111
//        1110 1010 1011 1001 1000 0000.
//     -> wrap high only on the 1000 -> 0000 step.
//     -> Exactly one bit changes on every step.
//  3. From bin_q = 0, set dir = 0 with inc_en = 1.
//     -> bin_q = 1111, gray_q = 1000, wrap = 1 for one cycle.
//     -> Next step: bin_q = 1110, gray_q = 1001, wrap = 0.
//  4. load = 1, load_bin = 1010, inc_en = 1 in the same cycle.
//     -> bin_q = 1010, gray_q = 1111, wrap = 0 (load wins).
//  5. Count up to bin_q = 0110, then assert rst between edges.
//     -> Outputs go to 0000/0000 asynchronously.
//     -> After release, counting resumes from 0.
//  6. Random load/inc_en/dir for 10k cycles against a reference model.
//     -> gray_q == bin2gray(bin_q) in every cycle.
//     -> The wrap count matches the model.

Source files
------------

// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the binary/Gray counter path.
//   GRAY_W_DEFAULT : default counter / Gray code width
//   step_sel_e     : next-state selection for the counter register
//   bin2gray()     : reference binary-to-Gray conversion, b ^ (b >> 1)
// -----------------------------------------------------------------------------
package gray_pkg;

    localparam int GRAY_W_DEFAULT = 4;

    // Which source feeds the counter register on the next edge.
    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_UP   = 2'd2,
        SEL_DOWN = 2'd3
    } step_sel_e;

    // Operates on a 32-bit container so it can serve any width up to 32.
    // Callers zero-extend their value and keep the low WIDTH bits.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage : gray_pkg

// File: rtl/bin2gray_comb.sv
// -----------------------------------------------------------------------------
// bin2gray_comb
// Purely combinational binary-to-Gray converter, WIDTH bits wide.
// Ports:
//   bin_i  [WIDTH-1:0] in   binary value
//   gray_o [WIDTH-1:0] out  Gray code of bin_i (bin_i ^ (bin_i >> 1))
// -----------------------------------------------------------------------------
module bin2gray_comb #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    // The MSB passes straight through; every lower bit is the XOR of itself
    // with its left neighbour.
    assign gray_o[WIDTH-1] = bin_i[WIDTH-1];

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
            assign gray_o[gi] = bin_i[gi] ^ bin_i[gi+1];
        end
    endgenerate

endmodule : bin2gray_comb

// File: rtl/bin2gray_counter.sv
// -----------------------------------------------------------------------------
// bin2gray_counter
// Registered binary up/down counter with a registered Gray-code copy of the
// count. Binary and Gray registers update on the same edge from the same
// next-state value, so they never skew against each other.
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous active-high reset
//   load     in   1      synchronous parallel load (highest priority)
//   load_bin in   WIDTH  value to load
//   inc_en   in   1      count enable, one step per clock
//   dir      in   1      1 = up, 0 = down
//   bin_q    out  WIDTH  registered binary count
//   gray_q   out  WIDTH  registered Gray code of bin_q
//   wrap     out  1      one-cycle pulse on a terminal-count crossing
// -----------------------------------------------------------------------------
module bin2gray_counter
    import gray_pkg::*;
#(
    parameter int               WIDTH     = GRAY_W_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    input  logic             inc_en,
    input  logic             dir,
    output logic [WIDTH-1:0] bin_q,
    output logic [WIDTH-1:0] gray_q,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VAL ^ (RESET_VAL >> 1);
    localparam logic [WIDTH-1:0] ALL_ONES   = '1;
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    logic [WIDTH-1:0] bin_cnt_q;
    logic [WIDTH-1:0] bin_cnt_d;
    logic [WIDTH-1:0] gray_cnt_q;
    logic [WIDTH-1:0] gray_cnt_d;
    logic             wrap_q;
    logic             wrap_d;
    step_sel_e        step_sel;

    // Priority: load > count > hold.
    always_comb begin
        step_sel = SEL_HOLD;
        if (load) begin
            step_sel = SEL_LOAD;
        end else if (inc_en) begin
            step_sel = dir ? SEL_UP : SEL_DOWN;
        end
    end

    // Next binary value; add/subtract wrap naturally modulo 2^WIDTH.
    always_comb begin
        bin_cnt_d = bin_cnt_q;
        case (step_sel)
            SEL_LOAD: bin_cnt_d = load_bin;
            SEL_UP:   bin_cnt_d = bin_cnt_q + ONE;
            SEL_DOWN: bin_cnt_d = bin_cnt_q - ONE;
            default:  bin_cnt_d = bin_cnt_q;
        endcase
    end

    // Terminal-count detect looks at the current value and the chosen step,
    // so a load in the same cycle always suppresses the pulse.
    always_comb begin
        wrap_d = 1'b0;
        if (step_sel == SEL_UP && bin_cnt_q == ALL_ONES) begin
            wrap_d = 1'b1;
        end else if (step_sel == SEL_DOWN && bin_cnt_q == '0) begin
            wrap_d = 1'b1;
        end
    end

    // Gray is encoded from the next binary value, not from bin_cnt_q, so the
    // Gray register lands on the same edge as the binary one.
    bin2gray_comb #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin_i  (bin_cnt_d),
        .gray_o (gray_cnt_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_cnt_q  <= RESET_VAL;
            gray_cnt_q <= RESET_GRAY;
            wrap_q     <= 1'b0;
        end else begin
            bin_cnt_q  <= bin_cnt_d;
            gray_cnt_q <= gray_cnt_d;
            wrap_q     <= wrap_d;
        end
    end

    // Outputs come straight from flops; no logic after the registers.
    assign bin_q  = bin_cnt_q;
    assign gray_q = gray_cnt_q;
    assign wrap   = wrap_q;

endmodule : bin2gray_counter

// File: tb/tb_bin2gray_counter.sv
module tb_bin2gray_counter;

    localparam int W    = 4;
    localparam int MODV = 16;

    logic         clk;
    logic         rst;
    logic         load;
    logic [W-1:0] load_bin;
    logic         inc_en;
    logic         dir;
    logic [W-1:0] bin_q;
    logic [W-1:0] gray_q;
    logic         wrap;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: integer count modulo 16 plus the expected wrap pulse.
    int m_bin;
    bit m_wrap;
    int m_wrap_count;
    int dut_wrap_count;

    bin2gray_counter #(
        .WIDTH     (W),
        .RESET_VAL (4'd0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_bin (load_bin),
        .inc_en   (inc_en),
        .dir      (dir),
        .bin_q    (bin_q),
        .gray_q   (gray_q),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] gray_of(input int b);
        int g;
        g = b ^ (b / 2);
        return g[W-1:0];
    endfunction

    function automatic logic [W-1:0] to_w(input int b);
        return b[W-1:0];
    endfunction

    // Update the model for one clock edge with the given inputs.
    task automatic model_edge(input bit l, input int lb, input bit en, input bit d);
        if (l) begin
            m_bin  = lb;
            m_wrap = 1'b0;
        end else if (en) begin
            if (d) begin
                m_wrap = (m_bin == MODV - 1);
                m_bin  = (m_bin + 1) % MODV;
            end else begin
                m_wrap = (m_bin == 0);
                m_bin  = (m_bin + MODV - 1) % MODV;
            end
        end else begin
            m_wrap = 1'b0;
        end
        if (m_wrap) m_wrap_count++;
    endtask

    // Drive inputs, advance one edge, sample 1 time unit after it.
    task automatic do_step(input bit l, input int lb, input bit en, input bit d);
        load     = l;
        load_bin = to_w(lb);
        inc_en   = en;
        dir      = d;
        @(posedge clk);
        model_edge(l, lb, en, d);
        #1;
        if (wrap) dut_wrap_count++;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 0; load_bin = '0; inc_en = 0; dir = 1;
        m_bin = 0; m_wrap = 0; m_wrap_count = 0; dut_wrap_count = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        n_total++;
        if (bin_q !== 4'b0000 || gray_q !== 4'b0000 || wrap !== 1'b0)
            $display("FAIL reset: bin=%b gray=%b wrap=%b, required 0000/0000/0", bin_q, gray_q, wrap);
        else n_pass++;
        $display("reset: bin=%b gray=%b wrap=%b", bin_q, gray_q, wrap);
    endtask

    task automatic test_count_up();
        logic [W-1:0] exp_seq [16];
        logic [W-1:0] prev_gray;
        exp_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                    4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        for (int i = 0; i < 16; i++) begin
            prev_gray = gray_q;
            do_step(0, 0, 1, 1);
            $display("up step %0d: bin=%b gray=%b wrap=%b", i, bin_q, gray_q, wrap);
            n_total++;
            if (gray_q !== exp_seq[i])
                $display("FAIL up_gray[%0d]: got %b, required %b", i, gray_q, exp_seq[i]);
            else n_pass++;
            n_total++;
            if (wrap !== (i == 15))
                $display("FAIL up_wrap[%0d]: got %b, required %b", i, wrap, (i == 15));
            else n_pass++;
            n_total++;
            if ($countones(prev_gray ^ gray_q) != 1)
                $display("FAIL up_onebit[%0d]: %b -> %b changed %0d bits, required 1",
                         i, prev_gray, gray_q, $countones(prev_gray ^ gray_q));
            else n_pass++;
        end
    endtask

    task automatic test_down_wrap();
        // Counter sits at 0 after the full up sweep.
        do_step(0, 0, 1, 0);
        $display("down step: bin=%b gray=%b wrap=%b", bin_q, gray_q, wrap);
        n_total++;
        if (bin_q !== 4'b1111 || gray_q !== 4'b1000 || wrap !== 1'b1)
            $display("FAIL down_wrap: got %b/%b/%b, required 1111/1000/1", bin_q, gray_q, wrap);
        else n_pass++;
        do_step(0, 0, 1, 0);
        $display("down step: bin=%b gray=%b wrap=%b", bin_q, gray_q, wrap);
        n_total++;
        if (bin_q !== 4'b1110 || gray_q !== 4'b1001 || wrap !== 1'b0)
            $display("FAIL down_next: got %b/%b/%b, required 1110/1001/0", bin_q, gray_q, wrap);
        else n_pass++;
        // Direction flip takes effect on the very next step.
        do_step(0, 0, 1, 1);
        $display("dir flip: bin=%b gray=%b wrap=%b", bin_q, gray_q, wrap);
        n_total++;
        if (bin_q !== 4'b1111 || gray_q !== 4'b1000)
            $display("FAIL dir_flip: got %b/%b, required 1111/1000", bin_q, gray_q);
        else n_pass++;
    endtask

    task automatic test_load_priority();
        // Counter is at 1111 counting up: a plain step would wrap, load must win.
        do_step(1, 10, 1, 1);
        $display("load: bin=%b gray=%b wrap=%b", bin_q, gray_q, wrap);
        n_total++;
        if (bin_q !== 4'b1010 || gray_q !== 4'b1111 || wrap !== 1'b0)
            $display("FAIL load_prio: got %b/%b/%b, required 1010/1111/0", bin_q, gray_q, wrap);
        else n_pass++;
        do_step(0, 3, 0, 1);
        $display("hold: bin=%b gray=%b wrap=%b", bin_q, gray_q, wrap);
        n_total++;
        if (bin_q !== 4'b1010 || gray_q !== 4'b1111 || wrap !== 1'b0)
            $display("FAIL hold: got %b/%b/%b, required 1010/1111/0", bin_q, gray_q, wrap);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_step(1, 0, 0, 1);
        for (int i = 0; i < 6; i++) do_step(0, 0, 1, 1);
        n_total++;
        if (bin_q !== 4'b0110)
            $display("FAIL pre_reset_count: got %b, required 0110", bin_q);
        else n_pass++;
        // Assert reset between edges and look before the next edge arrives.
        #2;
        rst = 1'b1;
        #1;
        $display("async reset: bin=%b gray=%b wrap=%b", bin_q, gray_q, wrap);
        n_total++;
        if (bin_q !== 4'b0000 || gray_q !== 4'b0000 || wrap !== 1'b0)
            $display("FAIL async_reset: got %b/%b/%b, required 0000/0000/0", bin_q, gray_q, wrap);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        m_bin = 0; m_wrap = 0;
        do_step(0, 0, 1, 1);
        $display("resume: bin=%b gray=%b wrap=%b", bin_q, gray_q, wrap);
        n_total++;
        if (bin_q !== 4'b0001 || gray_q !== 4'b0001)
            $display("FAIL resume: got %b/%b, required 0001/0001", bin_q, gray_q);
        else n_pass++;
    endtask

    task automatic test_random();
        bit l, en, d;
        int lb;
        m_wrap_count   = 0;
        dut_wrap_count = 0;
        for (int i = 0; i < 10000; i++) begin
            l  = ($urandom_range(0, 7) == 0);
            en = ($urandom_range(0, 3) != 0);
            d  = $urandom_range(0, 1);
            lb = $urandom_range(0, MODV - 1);
            do_step(l, lb, en, d);
            n_total++;
            if (bin_q !== to_w(m_bin) || gray_q !== gray_of(m_bin) || wrap !== m_wrap)
                $display("FAIL rand[%0d]: got %b/%b/%b, required %b/%b/%b",
                         i, bin_q, gray_q, wrap, to_w(m_bin), gray_of(m_bin), m_wrap);
            else n_pass++;
            n_total++;
            if (gray_q !== gray_of(int'(bin_q)))
                $display("FAIL rand_gray_rel[%0d]: gray=%b, required %b for bin=%b",
                         i, gray_q, gray_of(int'(bin_q)), bin_q);
            else n_pass++;
        end
        $display("random: model wraps=%0d dut wraps=%0d", m_wrap_count, dut_wrap_count);
        n_total++;
        if (dut_wrap_count != m_wrap_count)
            $display("FAIL wrap_count: got %0d, required %0d", dut_wrap_count, m_wrap_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_down_wrap();
        test_load_priority();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_bin2gray_counter
